// File: rtl/adc_channel_filter.sv
// adc_channel_filter: four-channel moving-average filter for a quad ADC front end.
// A captured conversion set is folded into the per-channel running sums one
// channel per clock (CH0..CH3). Averages are flagged valid once the window is full.
module adc_channel_filter #(
    parameter int WIN_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] ch0,
    input  logic [11:0] ch1,
    input  logic [11:0] ch2,
    input  logic [11:0] ch3,
    input  logic        clear,
    output logic [11:0] avg0,
    output logic [11:0] avg1,
    output logic [11:0] avg2,
    output logic [11:0] avg3,
    output logic        avg_valid,
    output logic        busy,
    output logic        overrun,
    output logic [11:0] peak0,
    output logic [7:0]  LEDs
);

    localparam int                  WIN       = 32'd1 << WIN_LOG2;
    localparam int                  ACC_W     = 32'd12 + WIN_LOG2;
    localparam logic [WIN_LOG2:0]   FILL_FULL = (WIN_LOG2 + 1)'(WIN);
    localparam logic [WIN_LOG2:0]   FILL_ONE  = (WIN_LOG2 + 1)'(1'b1);
    localparam logic [WIN_LOG2-1:0] WPTR_ONE  = WIN_LOG2'(1'b1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CH0  = 3'd1,
        CH1  = 3'd2,
        CH2  = 3'd3,
        CH3  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                busy_r;
    logic                avg_valid_r;
    logic                overrun_r;
    logic [11:0]         cap_r   [4];
    logic [11:0]         buf_r   [4][WIN];
    logic [ACC_W-1:0]    acc_r   [4];
    logic [11:0]         avg_r   [4];
    logic [11:0]         peak0_r;
    logic [7:0]          leds_r;
    logic [WIN_LOG2-1:0] wptr_r;
    logic [WIN_LOG2:0]   fill_r;

    logic                accept_s;
    logic                drop_s;
    logic                proc_s;
    logic                first_ch_s;
    logic                last_ch_s;
    logic [1:0]          ch_idx_s;
    logic [11:0]         old_s;
    logic [ACC_W-1:0]    acc_new_s;
    logic [11:0]         avg_new_s;
    logic [WIN_LOG2:0]   fill_next_s;

    // Bar graph: level+1 ones starting at bit 0 (level 0 -> 8'h01, level 7 -> 8'hFF).
    function automatic logic [7:0] therm_bar(input logic [2:0] level);
        logic [8:0] bar;
        bar = (9'd2 << level) - 9'd1;
        return bar[7:0];
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: clear aborts any set in flight.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sample_valid) begin
                        state_next_s = CH0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CH0:     state_next_s = CH1;
                CH1:     state_next_s = CH2;
                CH2:     state_next_s = CH3;
                CH3:     state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // FSM output decode: which channel is being folded in this cycle.
    always_comb begin
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        proc_s     = 1'b0;
        first_ch_s = 1'b0;
        last_ch_s  = 1'b0;
        ch_idx_s   = 2'd0;
        case (state_r)
            IDLE: accept_s = sample_valid;
            CH0: begin
                drop_s     = sample_valid;
                proc_s     = 1'b1;
                first_ch_s = 1'b1;
                ch_idx_s   = 2'd0;
            end
            CH1: begin
                drop_s   = sample_valid;
                proc_s   = 1'b1;
                ch_idx_s = 2'd1;
            end
            CH2: begin
                drop_s   = sample_valid;
                proc_s   = 1'b1;
                ch_idx_s = 2'd2;
            end
            CH3: begin
                drop_s    = sample_valid;
                proc_s    = 1'b1;
                last_ch_s = 1'b1;
                ch_idx_s  = 2'd3;
            end
            default: drop_s = sample_valid;
        endcase
    end

    // Running-sum update: the accumulator always equals the buffered entries, so it cannot wrap.
    always_comb begin
        old_s     = buf_r[ch_idx_s][wptr_r];
        acc_new_s = acc_r[ch_idx_s] - ACC_W'(old_s) + ACC_W'(cap_r[ch_idx_s]);
        avg_new_s = 12'(acc_new_s >> WIN_LOG2);
        if (fill_r == FILL_FULL) begin
            fill_next_s = fill_r;
        end else begin
            fill_next_s = fill_r + FILL_ONE;
        end
    end

    // Busy mirrors the registered state so it is a clean flop output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
        end
    end

    // Capture a coherent conversion set when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) cap_r[k] <= 12'h000;
        end else if (accept_s && !clear) begin
            cap_r[0] <= ch0;
            cap_r[1] <= ch1;
            cap_r[2] <= ch2;
            cap_r[3] <= ch3;
        end
    end

    // Sample history, accumulators and averages, one channel per state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                acc_r[k] <= '0;
                avg_r[k] <= 12'h000;
                for (int i = 0; i < WIN; i++) buf_r[k][i] <= 12'h000;
            end
        end else if (clear) begin
            for (int k = 0; k < 4; k++) begin
                acc_r[k] <= '0;
                avg_r[k] <= 12'h000;
                for (int i = 0; i < WIN; i++) buf_r[k][i] <= 12'h000;
            end
        end else if (proc_s) begin
            acc_r[ch_idx_s]         <= acc_new_s;
            avg_r[ch_idx_s]         <= avg_new_s;
            buf_r[ch_idx_s][wptr_r] <= cap_r[ch_idx_s];
        end
    end

    // Window pointer and fill count advance once per completed set; valid flags a full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_r      <= '0;
            fill_r      <= '0;
            avg_valid_r <= 1'b0;
        end else if (clear) begin
            wptr_r      <= '0;
            fill_r      <= '0;
            avg_valid_r <= 1'b0;
        end else begin
            avg_valid_r <= proc_s && last_ch_s && (fill_next_s == FILL_FULL);
            if (proc_s && last_ch_s) begin
                wptr_r <= wptr_r + WPTR_ONE;
                fill_r <= fill_next_s;
            end
        end
    end

    // Peak hold of avg0, sampled only on valid-average cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak0_r <= 12'h000;
        end else if (clear) begin
            peak0_r <= 12'h000;
        end else if (avg_valid_r && (avg_r[0] > peak0_r)) begin
            peak0_r <= avg_r[0];
        end
    end

    // Sticky overrun for sets dropped while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (clear) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end
    end

    // LED bar follows the freshly computed avg0 on the CH0 edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_r <= 8'h00;
        end else if (clear) begin
            leds_r <= 8'h01;
        end else if (proc_s && first_ch_s) begin
            leds_r <= therm_bar(avg_new_s[11:9]);
        end
    end

    assign avg0      = avg_r[0];
    assign avg1      = avg_r[1];
    assign avg2      = avg_r[2];
    assign avg3      = avg_r[3];
    assign avg_valid = avg_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign peak0     = peak0_r;
    assign LEDs      = leds_r;

endmodule
